// File: rtl/iter_recurrence.sv
// Iterative recurrence engine: y <- f(y, x, cnt) over a programmable number of accepted
// samples, with start/busy/done handshake, selectable update function and sticky overflow.
module iter_recurrence #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_iter,
   input  logic [1:0]       mode,
   input  logic [W-1:0]     init,
   input  logic             x_valid,
   input  logic [W-1:0]     x,
   output logic             x_ready,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     y,
   output logic             ovf
);

   localparam int unsigned FW = W + SHIFT + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] n_iter_q, n_iter_d;
   logic [1:0]       mode_q, mode_d;
   logic             ovf_q, ovf_d;

   logic [FW-1:0] y_ext, x_ext, full;
   logic          over;
   logic [W-1:0]  f_val;
   logic          first_bonus;

   assign y_ext       = FW'(y_q);
   assign x_ext       = FW'(x);
   assign first_bonus = (cnt_q == CNT_W'(1));

   // Full-width update; bits above W reveal overflow. Mode 3 can never overflow.
   always_comb begin
      full = '0;
      unique case (mode_q)
         2'd0:    full = (y_ext << SHIFT) + x_ext + {{(FW-1){1'b0}}, first_bonus};
         2'd1:    full = y_ext + x_ext;
         2'd2:    full = y_ext + x_ext;
         default: full = y_ext;
      endcase
   end

   assign over  = |full[FW-1:W];
   assign f_val = (mode_q == 2'd2 && over) ? {W{1'b1}} : full[W-1:0];

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      n_iter_d = n_iter_q;
      mode_d   = mode_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               y_d      = init;
               cnt_d    = '0;
               ovf_d    = 1'b0;
               n_iter_d = n_iter;
               mode_d   = mode;
               state_d  = (n_iter == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (x_valid) begin
               y_d   = f_val;
               cnt_d = cnt_q + CNT_W'(1);
               ovf_d = ovf_q | over;
               if (cnt_q == n_iter_q - CNT_W'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         y_q      <= '0;
         cnt_q    <= '0;
         n_iter_q <= '0;
         mode_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         n_iter_q <= n_iter_d;
         mode_q   <= mode_d;
         ovf_q    <= ovf_d;
      end
   end

   assign x_ready = (state_q == StRun);
   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign y       = y_q;
   assign ovf     = ovf_q;

endmodule
